// File: rtl/uart_rx_drain_ctrl.sv
// UART RX FIFO drain sequencer: decides when to empty the RX FIFO, pops one entry
// at a time onto a valid/ready stream, and drives the RDA/timeout interrupt levels.
module uart_rx_drain_ctrl #(
  parameter int FIFO_COUNTER_W = 5,
  parameter int REC_WIDTH      = 11,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                      clk,
  input  logic                      wb_rst_i,
  input  logic                      enable_i,
  input  logic                      flush_i,
  input  logic [1:0]                trig_level_i,
  input  logic [FIFO_COUNTER_W-1:0] rf_count,
  input  logic [REC_WIDTH-1:0]      rf_data_out,
  input  logic [9:0]                counter_t,
  output logic                      rf_pop,
  output logic [7:0]                m_data,
  output logic [2:0]                m_err,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      rda_int,
  output logic                      ti_int,
  output logic                      burst_active,
  output logic [ERR_CNT_W-1:0]      err_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] PRESENT = 2'd2;

  logic [1:0]                state;
  logic [1:0]                state_next;
  logic [FIFO_COUNTER_W-1:0] trig_val;
  logic                      fifo_nonempty;
  logic                      level_hit;
  logic                      timeout_hit;
  logic                      start;
  logic                      handshake;
  logic                      entry_has_err;

  always_comb begin
    trig_val = FIFO_COUNTER_W'(1);
    case (trig_level_i)
      2'b00:   trig_val = FIFO_COUNTER_W'(1);
      2'b01:   trig_val = FIFO_COUNTER_W'(4);
      2'b10:   trig_val = FIFO_COUNTER_W'(8);
      default: trig_val = FIFO_COUNTER_W'(14);
    endcase
  end

  assign fifo_nonempty = (rf_count != '0);
  assign level_hit     = (rf_count >= trig_val);
  assign timeout_hit   = (counter_t == '0);
  assign start         = enable_i && fifo_nonempty && (level_hit || timeout_hit);
  assign handshake     = m_valid && m_ready;
  assign entry_has_err = |rf_data_out[2:0];

  // Once a burst is running it keeps popping until the FIFO is empty,
  // regardless of the trigger level; flush overrides every transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = CAPTURE;
      end
      CAPTURE: begin
        state_next = PRESENT;
      end
      PRESENT: begin
        if (handshake) state_next = (enable_i && fifo_nonempty) ? CAPTURE : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (flush_i) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      rf_pop       <= 1'b0;
      burst_active <= 1'b0;
    end else begin
      state        <= state_next;
      // Registered so the pop strobe is high exactly during the CAPTURE cycle.
      rf_pop       <= (state_next == CAPTURE);
      burst_active <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_err   <= '0;
    end else begin
      if (state == CAPTURE) begin
        m_data <= rf_data_out[REC_WIDTH-1 -: 8];
        m_err  <= rf_data_out[2:0];
      end
      if (flush_i) begin
        m_valid <= 1'b0;
      end else if (state == CAPTURE) begin
        m_valid <= 1'b1;
      end else if (state == PRESENT && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Counts every popped entry with an error flag, including one dropped by flush.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_cnt <= '0;
    end else if (state == CAPTURE && entry_has_err && err_cnt != '1) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rda_int <= 1'b0;
      ti_int  <= 1'b0;
    end else begin
      rda_int <= level_hit;
      ti_int  <= timeout_hit && fifo_nonempty;
    end
  end

endmodule

// File: tb/tb_uart_rx_drain_ctrl.sv
// Scoreboard bench for uart_rx_drain_ctrl: a FIFO model feeds the DUT, expected
// stream words are queued at push time and checked by an independent monitor.
module tb_uart_rx_drain_ctrl;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        enable_i;
  logic        flush_i;
  logic [1:0]  trig_level_i;
  logic [4:0]  rf_count;
  logic [10:0] rf_data_out;
  logic [9:0]  counter_t;
  logic        rf_pop;
  logic [7:0]  m_data;
  logic [2:0]  m_err;
  logic        m_valid;
  logic        m_ready;
  logic        rda_int;
  logic        ti_int;
  logic        burst_active;
  logic [7:0]  err_cnt;

  int tests = 0;
  int fails = 0;
  int pop_cnt = 0;
  logic [10:0] fifo_q[$];
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_drain_ctrl #(.FIFO_COUNTER_W(5), .REC_WIDTH(11), .ERR_CNT_W(8)) dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .enable_i(enable_i), .flush_i(flush_i),
    .trig_level_i(trig_level_i), .rf_count(rf_count), .rf_data_out(rf_data_out),
    .counter_t(counter_t), .rf_pop(rf_pop), .m_data(m_data), .m_err(m_err),
    .m_valid(m_valid), .m_ready(m_ready), .rda_int(rda_int), .ti_int(ti_int),
    .burst_active(burst_active), .err_cnt(err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_sync();
    rf_count    = 5'(fifo_q.size());
    rf_data_out = (fifo_q.size() != 0) ? fifo_q[0] : 11'h0;
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] e);
    fifo_q.push_back({d, e});
    exp_q.push_back({d, e});
    fifo_sync();
  endtask

  // FIFO model: a pop seen during a cycle takes effect just after the next edge.
  task automatic fifo_model();
    logic pop_seen;
    forever begin
      @(negedge clk);
      pop_seen = rf_pop;
      @(posedge clk);
      #1;
      if (pop_seen) begin
        chk("pop_nonempty", 32'(fifo_q.size() != 0), 1);
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        fifo_sync();
      end
    end
  endtask

  task automatic monitor();
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (rf_pop) pop_cnt++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL stream_unexpected: got %0h expected none", m_data);
        end else begin
          e = exp_q.pop_front();
          chk("stream_data", m_data, e[10:3]);
          chk("stream_err", m_err, e[2:0]);
          $display("[TB] word data=%02h err=%03b", m_data, m_err);
        end
      end
    end
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 400 && !done; i++) begin
      if (!burst_active && !m_valid && fifo_q.size() == 0) done = 1'b1;
      else tick();
    end
    chk(name, 32'(done), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] pop_pat, burst_pat, rda_pat;
    int p0, remaining, n, exp_err;

    wb_rst_i = 1'b1; enable_i = 1'b1; flush_i = 1'b0; trig_level_i = 2'b00;
    counter_t = 10'h3FF; m_ready = 1'b1;
    fifo_sync();
    fork
      fifo_model();
      monitor();
    join_none
    tick();
    tick();
    chk("rst_rf_pop", rf_pop, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_burst", burst_active, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_rda", rda_int, 0);
    chk("rst_ti", ti_int, 0);
    wb_rst_i = 1'b0;
    tick();

    // Trigger level 4 reached with four entries.
    trig_level_i = 2'b01;
    p0 = pop_cnt;
    push(8'h11, 3'b000); push(8'h22, 3'b000); push(8'h33, 3'b000); push(8'h44, 3'b000);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pop_pat[i] = rf_pop;
      burst_pat[i] = burst_active;
      rda_pat[i] = rda_int;
    end
    chk("trig_pop_pattern", pop_pat, 12'h0AA);
    chk("trig_burst_pattern", burst_pat, 12'h1FE);
    chk("trig_rda_pattern", rda_pat, 12'h006);
    chk("trig_pop_count", pop_cnt - p0, 4);
    chk("trig_err_cnt", err_cnt, 0);

    // Below trigger level: drained only by the character timeout.
    trig_level_i = 2'b10;
    counter_t = 10'd5;
    push(8'hC1, 3'b000); push(8'hC2, 3'b000); push(8'hC3, 3'b000);
    for (int k = 5; k > 0; k--) begin
      tick();
      chk("to_no_pop", rf_pop, 0);
      chk("to_no_ti", ti_int, 0);
      counter_t = 10'(k - 1);
    end
    tick();
    chk("to_ti_set", ti_int, 1);
    chk("to_pop_start", rf_pop, 1);
    wait_idle("to_drain");
    tick();
    chk("to_ti_clear", ti_int, 0);
    counter_t = 10'h3FF;

    // Backpressure holds the word and blocks further pops.
    trig_level_i = 2'b00;
    m_ready = 1'b0;
    p0 = pop_cnt;
    push(8'hA1, 3'b000); push(8'hA2, 3'b000);
    tick(); tick(); tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", m_valid, 1);
      chk("bp_data", m_data, 8'hA1);
      chk("bp_count", rf_count, 1);
      chk("bp_no_pop", rf_pop, 0);
      tick();
    end
    chk("bp_single_pop", pop_cnt - p0, 1);
    m_ready = 1'b1;
    wait_idle("bp_drain");
    chk("bp_total_pops", pop_cnt - p0, 2);

    // Error counting and saturation.
    push(8'h5A, 3'b010); push(8'h5B, 3'b100); push(8'h5C, 3'b000);
    wait_idle("err_drain");
    chk("err_cnt_two", err_cnt, 2);
    exp_err = 2;
    remaining = 255;
    while (remaining > 0) begin
      n = (remaining > 16) ? 16 : remaining;
      for (int j = 0; j < n; j++) push(8'(j + 8'h80), 3'(j % 7 + 1));
      remaining -= n;
      wait_idle("sat_drain");
      exp_err = (exp_err + n > 255) ? 255 : exp_err + n;
      chk("err_cnt_batch", err_cnt, exp_err);
    end
    chk("err_cnt_sat", err_cnt, 8'hFF);

    // Flush discards the pending word.
    m_ready = 1'b0;
    push(8'h77, 3'b000); push(8'h78, 3'b000);
    tick(); tick(); tick();
    chk("fl_valid_before", m_valid, 1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fl_valid", m_valid, 0);
    chk("fl_burst", burst_active, 0);
    chk("fl_pop", rf_pop, 0);
    void'(exp_q.pop_front());
    m_ready = 1'b1;
    wait_idle("fl_drain");
    chk("fl_err_cnt", err_cnt, 8'hFF);

    // Enable low: RDA still reported at the 14-entry boundary but nothing pops.
    enable_i = 1'b0;
    trig_level_i = 2'b11;
    p0 = pop_cnt;
    for (int j = 0; j < 13; j++) push(8'(8'h30 + j), 3'b000);
    tick(); tick();
    chk("en_rda_13", rda_int, 0);
    push(8'h3D, 3'b000);
    tick(); tick();
    chk("en_rda_14", rda_int, 1);
    for (int i = 0; i < 4; i++) begin
      chk("en_no_pop", rf_pop, 0);
      chk("en_no_burst", burst_active, 0);
      tick();
    end
    chk("en_pop_count", pop_cnt - p0, 0);
    enable_i = 1'b1;
    wait_idle("en_drain");
    chk("en_total_pops", pop_cnt - p0, 14);

    // Asynchronous reset in the middle of CAPTURE.
    trig_level_i = 2'b00;
    push(8'hE1, 3'b000); push(8'hE2, 3'b000); push(8'hE3, 3'b000);
    tick();
    chk("rb_in_capture", rf_pop, 1);
    wb_rst_i = 1'b1;
    #1;
    chk("rb_pop", rf_pop, 0);
    chk("rb_valid", m_valid, 0);
    chk("rb_burst", burst_active, 0);
    chk("rb_err_cnt", err_cnt, 0);
    enable_i = 1'b0;
    tick(); tick();
    wb_rst_i = 1'b0;
    p0 = pop_cnt;
    tick(); tick(); tick();
    chk("rb_no_pop", pop_cnt - p0, 0);
    chk("rb_count", rf_count, 3);
    enable_i = 1'b1;
    wait_idle("rb_drain");
    chk("rb_total_pops", pop_cnt - p0, 3);

    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_drain_ctrl.md
Name: uart_rx_drain_ctrl

Overview:
Receive-side sequencer for the UART RX FIFO. It decides when the FIFO is drained: when the fill level reaches the programmed trigger level, or when the character timeout (counter_t) expires with data pending. It pops entries one at a time and presents each data byte and its error flags on a valid/ready stream to a local consumer. It also produces the received-data-available and timeout interrupt levels, plus a saturating error counter.

Parameters:
FIFO_COUNTER_W, 5, width of rf_count (FIFO depth 16).
REC_WIDTH, 11, FIFO entry width: [10:3] data, [2] break, [1] parity error, [0] framing error.
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
clk  in  1  clock
wb_rst_i  in  1  asynchronous active-high reset
enable_i  in  1  drain enable; when low, no new pop starts
flush_i  in  1  synchronous abort of the current burst/stream word
trig_level_i  in  2  FCR[7:6] trigger: 00=1, 01=4, 10=8, 11=14 entries
rf_count  in  FIFO_COUNTER_W  FIFO fill level; updates the cycle after a pop
rf_data_out  in  REC_WIDTH  FIFO head entry, valid whenever rf_count!=0
counter_t  in  10  character-timeout counter; 0 = expired
rf_pop  out  1  one-cycle FIFO pop strobe
m_data  out  8  received byte
m_err  out  3  {break, parity, framing} of m_data
m_valid  out  1  stream valid
m_ready  in  1  stream ready
rda_int  out  1  level: rf_count >= trigger level
ti_int  out  1  level: timeout with data pending
burst_active  out  1  drain burst in progress
err_cnt  out  ERR_CNT_W  count of popped entries with any error bit set; saturating

Behaviour:
- Reset: wb_rst_i is asynchronous, active-high; clock is clk. Reset drives state=IDLE and clears rf_pop, m_valid, m_data, m_err, rda_int, ti_int, burst_active and err_cnt to 0.
- trig_val = {1,4,8,14}[trig_level_i], zero-extended to FIFO_COUNTER_W.
- rda_int is registered: rda_int <= (rf_count >= trig_val).
- ti_int is registered: ti_int <= (counter_t==0 && rf_count!=0).
- start = enable_i && rf_count!=0 && (rf_count>=trig_val || counter_t==0).
- FSM states: IDLE, CAPTURE, PRESENT.
- IDLE:
  - burst_active=0.
  - If start: go to CAPTURE and set burst_active=1.
- CAPTURE (exactly one cycle):
  - Latch m_data=rf_data_out[10:3] and m_err=rf_data_out[2:0].
  - rf_pop=1 for this cycle only. Set m_valid=1.
  - err_cnt+1 if |rf_data_out[2:0], holding at all-ones.
  - Go to PRESENT.
- PRESENT:
  - m_data and m_err are held stable while m_valid && !m_ready.
  - On m_valid && m_ready: clear m_valid.
    - If enable_i && rf_count!=0: go to CAPTURE. rf_count already reflects the pop by this point.
    - Otherwise go to IDLE and clear burst_active.
  - A burst therefore continues until the FIFO is empty, even if rf_count falls below trig_val.
- Throughput: at most one entry per 2 cycles. Latency from start to m_valid is 2 cycles: one to enter CAPTURE, one for m_valid to register.
- rf_pop is never asserted when rf_count==0. The FSM only enters CAPTURE with rf_count!=0.
- enable_i low in PRESENT: the pending word still completes its handshake, then the FSM goes to IDLE.
- flush_i: next cycle the FSM is in IDLE, m_valid=0, burst_active=0 and rf_pop=0. The pending word is discarded. flush_i has priority over the handshake and over start. err_cnt is unaffected.
- Reset mid-burst: all outputs go to 0 immediately (asynchronous). Entries already popped are lost; no re-pop.
- The m_valid/m_ready rule follows standard valid/ready: m_valid never drops without a handshake, except on flush_i or reset.

Test Plan:
- Trigger: trig_level_i=01, fill the FIFO model with 4 bytes 0x11,0x22,0x33,0x44 and hold m_ready=1 → rda_int=1; exactly 4 rf_pop pulses spaced 2 cycles apart; stream emits 0x11..0x44 in order with m_err=0; burst_active falls after the last handshake; err_cnt=0.
- Below trigger, then timeout: trig_level_i=10, 3 entries present, counter_t=5 counting down → no pop until counter_t==0; then ti_int=1 and 3 bytes drain; ti_int=0 once rf_count==0.
- Backpressure: 2 entries, m_ready low for 10 cycles → m_data and m_valid stay stable, a single rf_pop occurs, rf_count stays at 1; after m_ready goes high, the second entry is popped.
- Errors and saturation: entries with m_err=3'b010, 3'b100, 3'b000 → err_cnt=2. Preload with 255 further errored entries (ERR_CNT_W=8) → err_cnt stays at 0xFF.
- Flush and enable: flush_i asserted while m_valid=1 → m_valid=0 next cycle and the FSM is in IDLE. enable_i=0 with rf_count=14 and trig_level_i=11 → rda_int=1 but no rf_pop.
- Reset mid-burst: assert wb_rst_i during CAPTURE → rf_pop, m_valid, burst_active and err_cnt are 0 immediately, with no further pops until start re-occurs.
